round_controller: RTL
=====================

Name: round_controller

Overview:
- Sits directly downstream of the bullet hit detector and consumes its per-frame player_1_hit / player_2_hit levels.
- Converts those levels into scoring events.
- Owns the authoritative match scores, the post-hit pause/respawn sequence, bullet-clear requests and game-over/winner state.
- Outputs drive the player/bullet motion blocks (freeze, clear, respawn) and the score/colour mapper (scores, flash, winner).

Parameters:
- WIN_SCORE, 5: score at which a match ends; legal range 1..31.
- PAUSE_FRAMES, 60: length of the post-hit pause in frames; legal range 2..255.
- FLASH_BIT, 2: bit of the pause counter that gates the hit-player flash; legal range 0..7.

Ports:
- frame_clk  in  1  frame-rate clock (one edge per video frame)
- Reset  in  1  asynchronous, active-high reset
- player_1_hit  in  1  level; high while P2's bullet overlaps P1
- player_2_hit  in  1  level; high while P1's bullet overlaps P2
- start  in  1  level from restart key; only its rising edge is used
- p1_score  out  5  P1 match score
- p2_score  out  5  P2 match score
- freeze  out  1  high: player and bullet motion blocks hold position
- bullet_clear_1  out  1  one-frame pulse: despawn P1's bullet
- bullet_clear_2  out  1  one-frame pulse: despawn P2's bullet
- respawn  out  1  one-frame pulse: players return to spawn points
- p1_flash  out  1  P1 blink enable during pause
- p2_flash  out  1  P2 blink enable during pause
- game_over  out  1  high in OVER state
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset: Reset is asynchronous, active-high; clock is frame_clk. On Reset:
  - state=PLAY, all scores and counters 0, edge registers 0.
  - Every output 0; winner=00.
- Reset mid-operation: any state returns immediately to these values.
- All outputs are registered. A rising input sampled at edge N is reflected in the outputs after edge N.
- Edge detection:
  - rise_x = x & ~x_d, where x_d is the previous-frame sample.
  - x_d updates every frame in every state.
  - A hit level held across a pause therefore never re-triggers.
- State PLAY (freeze=0):
  - No rise: stay in PLAY.
  - Rise on player_2_hit: p1_score+1; bullet_clear_1 pulses; hit mask = P2.
  - Rise on player_1_hit: p2_score+1; bullet_clear_2 pulses; hit mask = P1.
  - Both rises in the same frame: both scores increment, both clears pulse, mask = both (a trade).
  - Scores saturate at WIN_SCORE and never wrap.
  - After any scoring event:
    - If either score now equals WIN_SCORE: go to OVER. winner = 01, 10, or 11 if both reached it on the same edge.
    - Otherwise: go to PAUSE, load cnt = PAUSE_FRAMES-1.
- State PAUSE (freeze=1):
  - Hits are ignored and do not score.
  - cnt decrements by 1 per frame.
  - pN_flash = mask_N & cnt[FLASH_BIT].
  - When cnt==0: go to PLAY, respawn pulses for exactly one frame, flash=0, mask cleared.
  - Total freeze duration is exactly PAUSE_FRAMES frames.
- State OVER (freeze=1, game_over=1):
  - winner and scores are held; hits are ignored; flash=0.
  - A start rising edge clears scores and winner, goes to PLAY, and pulses respawn for one frame.
- start edges in PLAY or PAUSE are ignored.
- start_d tracks every frame, so a start held through Reset does not restart the match on release.
- Pulse outputs (bullet_clear_*, respawn) are never high for two consecutive frames.

Decomposition:
- Shared package game_pkg holds:
  - the state typedef (enum PLAY, PAUSE, OVER);
  - the winner encoding constants (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW);
  - SCORE_W=5.
- Sub-module rise_det: 1-bit registered rising-edge detector with async Reset. Three instances: player_1_hit, player_2_hit, start.
- FSM, counter and scoring stay in round_controller.

Test Plan:
- Reset, then player_2_hit 0→1 held 10 frames → p1_score=1 after the first edge only; bullet_clear_1 high for 1 frame; freeze high for exactly 60 frames; respawn pulses on frame 61; p2_score=0.
- player_1_hit and player_2_hit rise on the same frame with scores 2/2 → scores 3/3, both clears pulse, p1_flash and p2_flash both toggle with period 8 frames during pause.
- p1_score=4, player_2_hit rises → p1_score=5, game_over=1, winner=01, freeze=1, no respawn; further hits leave scores unchanged.
- Scores 4/4, simultaneous rises → 5/5, winner=11.
- In OVER, pulse start high → scores 0/0, winner=00, game_over=0, respawn single pulse. start asserted during PAUSE → no effect.
- Assert Reset asynchronously mid-PAUSE (cnt=30) → all outputs 0 immediately; PLAY resumes; a hit level still high at Reset release does not score until it falls and rises again.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the round/scoring logic of the two-player game.
package game_pkg;

    localparam int SCORE_W = 5;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        PAUSE = 2'd1,
        OVER  = 2'd2
    } round_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Increment a score but never past the match-winning value.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                   input logic [SCORE_W-1:0] limit);
        return (score >= limit) ? limit : score + {{(SCORE_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rise_det.sv
// One-bit rising-edge detector on a frame-rate level.
// The previous-frame sample clears to 0 on Reset, and the first frame after
// Reset release only primes the sampler, so a level that was already high
// while Reset was asserted is treated as held and never produces a rise.
module rise_det (
    input  logic frame_clk,
    input  logic Reset,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;
    logic armed_q;

    // Track the previous-frame sample every frame and arm after the first sample.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            level_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            level_q <= level_i;
            armed_q <= 1'b1;
        end
    end

    assign rise_o = level_i & ~level_q & armed_q;

endmodule

// File: rtl/round_controller.sv
// Round controller: turns hit levels into scoring events, runs the post-hit
// freeze/respawn sequence, and holds the match result until a restart.
// Every output comes straight from a register.
module round_controller
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_FRAMES = 60,
    parameter int FLASH_BIT    = 2
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               player_1_hit,
    input  logic               player_2_hit,
    input  logic               start,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               freeze,
    output logic               bullet_clear_1,
    output logic               bullet_clear_2,
    output logic               respawn,
    output logic               p1_flash,
    output logic               p2_flash,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         PAUSE_LOAD = 8'(PAUSE_FRAMES - 1);

    logic rise_p1_hit;
    logic rise_p2_hit;
    logic rise_start;

    rise_det u_rise_p1_hit (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .level_i   (player_1_hit),
        .rise_o    (rise_p1_hit)
    );

    rise_det u_rise_p2_hit (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .level_i   (player_2_hit),
        .rise_o    (rise_p2_hit)
    );

    rise_det u_rise_start (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .level_i   (start),
        .rise_o    (rise_start)
    );

    round_state_t       state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         mask_q, mask_d;      // bit0 = P1 was hit, bit1 = P2 was hit
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               freeze_q, freeze_d;
    logic               clear1_q, clear1_d;
    logic               clear2_q, clear2_d;
    logic               respawn_q, respawn_d;
    logic               flash1_q, flash1_d;
    logic               flash2_q, flash2_d;
    logic               over_q, over_d;

    // State, counter, scores and registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= PLAY;
            cnt_q     <= '0;
            mask_q    <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            winner_q  <= WIN_NONE;
            freeze_q  <= 1'b0;
            clear1_q  <= 1'b0;
            clear2_q  <= 1'b0;
            respawn_q <= 1'b0;
            flash1_q  <= 1'b0;
            flash2_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            winner_q  <= winner_d;
            freeze_q  <= freeze_d;
            clear1_q  <= clear1_d;
            clear2_q  <= clear2_d;
            respawn_q <= respawn_d;
            flash1_q  <= flash1_d;
            flash2_q  <= flash2_d;
            over_q    <= over_d;
        end
    end

    // Next-state logic; output values are derived from the next state so they
    // line up with the frame in which the state takes effect.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        winner_d  = winner_q;
        clear1_d  = 1'b0;
        clear2_d  = 1'b0;
        respawn_d = 1'b0;

        case (state_q)
            PLAY: begin
                if (rise_p1_hit || rise_p2_hit) begin
                    if (rise_p2_hit) begin
                        p1_d     = sat_inc(p1_q, WIN_VAL);
                        clear1_d = 1'b1;
                    end
                    if (rise_p1_hit) begin
                        p2_d     = sat_inc(p2_q, WIN_VAL);
                        clear2_d = 1'b1;
                    end
                    if ((p1_d == WIN_VAL) || (p2_d == WIN_VAL)) begin
                        state_d  = OVER;
                        winner_d = {p2_d == WIN_VAL, p1_d == WIN_VAL};
                        mask_d   = 2'b00;
                    end else begin
                        state_d = PAUSE;
                        cnt_d   = PAUSE_LOAD;
                        mask_d  = {rise_p2_hit, rise_p1_hit};
                    end
                end
            end
            PAUSE: begin
                if (cnt_q == 8'd0) begin
                    state_d   = PLAY;
                    mask_d    = 2'b00;
                    respawn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            OVER: begin
                if (rise_start) begin
                    state_d   = PLAY;
                    p1_d      = '0;
                    p2_d      = '0;
                    winner_d  = WIN_NONE;
                    respawn_d = 1'b1;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase

        freeze_d = (state_d != PLAY);
        over_d   = (state_d == OVER);
        flash1_d = (state_d == PAUSE) & mask_d[0] & cnt_d[FLASH_BIT];
        flash2_d = (state_d == PAUSE) & mask_d[1] & cnt_d[FLASH_BIT];
    end

    assign p1_score       = p1_q;
    assign p2_score       = p2_q;
    assign freeze         = freeze_q;
    assign bullet_clear_1 = clear1_q;
    assign bullet_clear_2 = clear2_q;
    assign respawn        = respawn_q;
    assign p1_flash       = flash1_q;
    assign p2_flash       = flash2_q;
    assign game_over      = over_q;
    assign winner         = winner_q;

endmodule
